// File: rtl/shader_pkg.sv
// shader_pkg: shared types for the triangle dispatcher and shader interface
package shader_pkg;

    localparam int VERT_WORD_W = 32;

    typedef logic [15:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } vertex_t;

    typedef enum logic [3:0] {
        IDLE,
        FACE_RD,
        FACE_CAP,
        V1,
        V2,
        V3,
        ISSUE,
        WAIT_DONE,
        NEXT
    } disp_state_t;

endpackage

// File: rtl/triangle_dispatcher.sv
// triangle_dispatcher: walks the face list, fetches vertices and hands each triangle to the shader
module triangle_dispatcher
    import shader_pkg::*;
#(
    parameter int NUM_FACES = 32,
    parameter int FACE_AW   = 10,
    parameter int VERT_AW   = 10,
    parameter int START_LEN = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    output logic                     busy,
    output logic                     frame_done,
    output logic [FACE_AW-1:0]       face_idx,
    output logic [15:0]              culled_cnt,
    output logic                     face_rd,
    output logic [FACE_AW-1:0]       face_addr,
    input  logic [3*VERT_AW-1:0]     face_data,
    output logic                     vert_rd,
    output logic [VERT_AW-1:0]       vert_addr,
    input  logic [VERT_WORD_W-1:0]   vert_data,
    output logic [15:0]              v1x,
    output logic [15:0]              v1y,
    output logic [15:0]              v2x,
    output logic [15:0]              v2y,
    output logic [15:0]              v3x,
    output logic [15:0]              v3y,
    output logic                     start,
    input  logic                     done
);

    disp_state_t          r_state;
    disp_state_t          w_next;
    logic [15:0]          r_issue_cnt;
    logic                 r_done_flag;
    logic [FACE_AW-1:0]   r_face_idx;
    logic [FACE_AW-1:0]   r_face_addr;
    logic [15:0]          r_culled;
    logic [VERT_AW-1:0]   r_i2;
    logic [VERT_AW-1:0]   r_i3;
    logic [VERT_AW-1:0]   r_vert_addr;
    vertex_t              r_v1;
    vertex_t              r_v2;
    vertex_t              r_v3;
    logic [VERT_AW-1:0]   w_i1;
    logic [VERT_AW-1:0]   w_i2;
    logic [VERT_AW-1:0]   w_i3;
    logic                 w_degen;
    logic                 w_last;
    logic [VERT_AW-1:0]   w_vert_addr;

    assign w_i1    = face_data[3*VERT_AW-1 -: VERT_AW];
    assign w_i2    = face_data[2*VERT_AW-1 -: VERT_AW];
    assign w_i3    = face_data[VERT_AW-1:0];
    assign w_degen = (w_i1 == w_i2) || (w_i2 == w_i3) || (w_i1 == w_i3);
    assign w_last  = r_face_idx == FACE_AW'(NUM_FACES - 1);

    // Next-state selection for the per-face fetch/issue sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = go ? FACE_RD : IDLE;
            FACE_RD:   w_next = FACE_CAP;
            FACE_CAP:  w_next = w_degen ? NEXT : V1;
            V1:        w_next = V2;
            V2:        w_next = V3;
            V3:        w_next = ISSUE;
            ISSUE:     w_next = (r_issue_cnt == 16'(START_LEN - 1)) ? WAIT_DONE : ISSUE;
            WAIT_DONE: w_next = r_done_flag ? NEXT : WAIT_DONE;
            NEXT:      w_next = w_last ? IDLE : FACE_RD;
            default:   w_next = IDLE;
        endcase
    end

    // Vertex address follows the captured indices and holds between reads
    always_comb begin
        w_vert_addr = r_vert_addr;
        if (r_state == FACE_CAP && !w_degen) w_vert_addr = w_i1;
        else if (r_state == V1) w_vert_addr = r_i2;
        else if (r_state == V2) w_vert_addr = r_i3;
    end

    // Sequencer state, start-length counter and sticky done flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_issue_cnt <= '0;
            r_done_flag <= 1'b0;
            r_vert_addr <= '0;
        end else begin
            r_state     <= w_next;
            r_issue_cnt <= (r_state == ISSUE) ? r_issue_cnt + 16'd1 : '0;
            r_done_flag <= (r_state == ISSUE || r_state == WAIT_DONE) && (r_done_flag || done);
            r_vert_addr <= w_vert_addr;
        end
    end

    // Face bookkeeping: index, face address, culled counter and captured indices
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_face_idx  <= '0;
            r_face_addr <= '0;
            r_culled    <= '0;
            r_i2        <= '0;
            r_i3        <= '0;
        end else begin
            if (r_state == IDLE && go) begin
                r_face_idx  <= '0;
                r_face_addr <= '0;
                r_culled    <= '0;
            end
            if (r_state == NEXT && !w_last) begin
                r_face_idx  <= r_face_idx + 1'b1;
                r_face_addr <= r_face_idx + 1'b1;
            end
            if (r_state == FACE_CAP) begin
                r_i2 <= w_i2;
                r_i3 <= w_i3;
                if (w_degen && r_culled != 16'hFFFF) r_culled <= r_culled + 16'd1;
            end
        end
    end

    // Vertex capture registers, written only while fetching a face
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1 <= '0;
            r_v2 <= '0;
            r_v3 <= '0;
        end else begin
            if (r_state == V1) r_v1 <= vertex_t'(vert_data);
            if (r_state == V2) r_v2 <= vertex_t'(vert_data);
            if (r_state == V3) r_v3 <= vertex_t'(vert_data);
        end
    end

    assign busy       = r_state != IDLE;
    assign start      = r_state == ISSUE;
    assign frame_done = r_state == NEXT && w_last;
    assign face_rd    = r_state == FACE_RD;
    assign vert_rd    = (r_state == FACE_CAP && !w_degen) || r_state == V1 || r_state == V2;
    assign face_addr  = r_face_addr;
    assign vert_addr  = w_vert_addr;
    assign face_idx   = r_face_idx;
    assign culled_cnt = r_culled;
    assign v1x        = r_v1.x;
    assign v1y        = r_v1.y;
    assign v2x        = r_v2.x;
    assign v2y        = r_v2.y;
    assign v3x        = r_v3.x;
    assign v3y        = r_v3.y;

endmodule

// File: doc/triangle_dispatcher.md
Name: triangle_dispatcher

Overview:
- Initiator-side driver for the shader's triangle interface.
- Walks a face list in memory, fetches the three vertex coordinates per face from a vertex memory, and presents them on v1x..v3y.
- Pulses start, holds the vertices stable, then waits for the shader's done before issuing the next face.
- Sits between the scene memories and the shader, replacing hand-driven stimulus with a frame-level "go".

Parameters:
- NUM_FACES, 32, faces per frame (must be ≥1).
- FACE_AW, 10, face memory address width.
- VERT_AW, 10, vertex index/address width.
- START_LEN, 2, cycles start is held high per face.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  begin frame; sampled only in IDLE.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse after the last face completes.
- face_idx  out  FACE_AW  index of the current face.
- culled_cnt  out  16  degenerate faces skipped this frame; saturating.
- face_rd  out  1  face memory read strobe.
- face_addr  out  FACE_AW  face memory address.
- face_data  in  3*VERT_AW  {i1,i2,i3}, i1 in MSBs; valid the cycle after face_rd.
- vert_rd  out  1  vertex memory read strobe.
- vert_addr  out  VERT_AW  vertex memory address.
- vert_data  in  32  {x[31:16], y[15:0]}; valid the cycle after vert_rd.
- v1x, v1y, v2x, v2y, v3x, v3y  out  16 each  vertex coordinates to the shader.
- start  out  1  shader start.
- done  in  1  shader completion.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE.
  - All outputs 0: start, busy, frame_done, face_rd, vert_rd, face_idx, culled_cnt, face_addr, vert_addr, v*.
- States: IDLE, FACE_RD, FACE_CAP, V1, V2, V3, ISSUE, WAIT_DONE, NEXT.
- Timing (cycle n = go sampled high in IDLE):
  - On go: face_idx=0 and culled_cnt=0.
  - n+1 FACE_RD: face_rd=1, face_addr=face_idx.
  - n+2 FACE_CAP: capture the indices.
    - Degenerate face (i1==i2 or i2==i3 or i1==i3): increment culled_cnt, go to NEXT. No vertex reads, no start.
    - Otherwise: vert_rd=1, vert_addr=i1.
  - n+3 V1: vert_rd addr=i2; capture v1 from vert_data.
  - n+4 V2: vert_rd addr=i3; capture v2.
  - n+5 V3: capture v3.
  - n+6 .. n+5+START_LEN ISSUE: start=1, then WAIT_DONE.
- Vertex stability: v1x..v3y are registered and change only during V1/V2/V3 captures. They are stable from the first start cycle until done is seen.
- done handling:
  - done is sampled in ISSUE and WAIT_DONE.
  - A done seen in ISSUE is latched in a sticky flag, and WAIT_DONE exits on its first cycle.
  - start still completes its full START_LEN.
  - done seen in any other state is ignored.
- NEXT (one cycle):
  - If face_idx==NUM_FACES-1: frame_done=1 for this cycle, then IDLE. face_idx holds its last value.
  - Otherwise: face_idx+1, then FACE_RD.
- Strobes: face_rd and vert_rd are only asserted in the states listed above. Addresses hold their last value when strobes are low.
- go while busy is ignored.
- go asserted in the frame_done cycle is ignored; it is only accepted in IDLE.
- culled_cnt saturates at 16'hFFFF.
- No timeout: WAIT_DONE waits indefinitely. reset is the only escape.
- Reset mid-operation: start drops asynchronously and the in-flight face is abandoned. The next go restarts at face 0.

Decomposition:
- Shared package shader_pkg:
  - coord_t (logic [15:0]).
  - vertex_t struct {coord_t x; coord_t y;}.
  - disp_state_t enum.
  - constant VERT_WORD_W=32.
- No sub-module. The block is a single FSM with a capture datapath.

Test Plan:
- Single face, NUM_FACES=1. face0={0,1,2}; vert0=30A9_1AB2, vert1=315F_1B57, vert2=27FC_1B5F; go at n.
  - start high exactly cycles n+6, n+7.
  - v1x=30A9, v1y=1AB2, v2x=315F, v2y=1B57, v3x=27FC, v3y=1B5F during start.
  - done returned at n+20 gives frame_done at n+22; busy low at n+23.
- Early done: done pulsed in the second start cycle.
  - start still lasts 2 cycles.
  - NEXT follows the cycle after ISSUE ends; no hang.
- Culling, NUM_FACES=3. face1={5,5,7}, faces 0 and 2 valid.
  - Exactly two start pulses; no vert_rd for face 1; culled_cnt=1 at frame_done.
- Vertex hold: shader delays done 200 cycles.
  - v* and face_idx stay constant throughout.
  - No face_rd or vert_rd during WAIT_DONE.
- Reset mid-WAIT_DONE: assert reset asynchronously between clock edges.
  - start, busy and v* go to 0 immediately.
  - A new go re-fetches from face_addr=0.
- go during busy and stray done: go pulsed in V2 and done pulsed in IDLE.
  - Neither changes state or counters.
